instr_fetch: RTL

Instruction fetch unit for the single-cycle datapath. It owns the program counter and drives the 3-bit read address of the instruction memory. It captures each 16-bit instruction word into an instruction register and presents it to decode through a valid/ready handshake. It also handles branch redirects and back-pressure from decode.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/instr_fetch_pc_reg.sv | 34 +++
 rtl/instr_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-cycle datapath.
//   DEF_ADDR_W / DEF_INSTR_W : default PC and instruction word widths
//   fetch_state_t            : instruction fetch FSM encoding
//   HALT_OPCODE              : opcode (word[15:12]) that stops fetch when
//                              the IF_HALT_EN build macro is defined
package datapath_pkg;

  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [3:0] HALT_OPCODE = 4'hF;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register for instr_fetch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pc -> 0)
//   inc        : advance pc by one, wrapping modulo 2^ADDR_W
//   load       : load target (highest priority)
//   hold       : keep pc (overrides inc)
//   target     : redirect address
//   pc         : current program counter
module pc_reg #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic              hold,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= target;
    end else if (hold) begin
      pc <= pc;
    end else if (inc) begin
      // Natural overflow of the ADDR_W-bit sum gives the wrap to 0.
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads instruction memory
// combinationally at mem_addr, captures the word into an instruction
// register and offers it to decode.
// Build option: IF_HALT_EN -- when defined, capturing a word whose
// opcode is HALT_OPCODE stops fetch in the HALT state until reset.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   mem_addr       : instruction memory read address (= pc)
//   mem_instr      : instruction word for mem_addr (same cycle)
//   branch_en      : redirect request
//   branch_target  : redirect address
//   out_valid      : ir_out / pc_out hold a fetched instruction
//   out_ready      : decode accepts the instruction this cycle
//   ir_out, pc_out : instruction register and its fetch address
//   halted         : fetch stopped on a halt word (0 without IF_HALT_EN)
//   fetch_state    : current FSM state (fetch_state_t encoding)
//
// Handshake: a transfer happens at the rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, ir_out and pc_out do not
// change. A branch in the same cycle discards the offered instruction even
// if out_ready=1.
module instr_fetch
  import datapath_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted,
  output logic [1:0]         fetch_state
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              branch;
  logic              capture;
  logic              stall;
  logic              pc_hold;

  // Branches are honoured only while fetching; IDLE and HALT ignore them.
  assign branch  = branch_en && ((state == RUN) || (state == HOLD));

  // Capture whenever the output slot is empty or being drained this cycle.
  assign capture = !branch &&
                   (((state == RUN)  && (!out_valid || out_ready)) ||
                    ((state == HOLD) && out_ready));

  assign stall   = !branch && !capture;

`ifdef IF_HALT_EN
  logic halt_hit;
  logic halted_q;

  assign halt_hit = capture && (mem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign halted   = halted_q;
  // The pc stays on the halt word's address.
  assign pc_hold  = stall || halt_hit;
`else
  assign halted   = 1'b0;
  assign pc_hold  = stall;
`endif

  assign mem_addr    = pc;
  assign fetch_state = state;

  pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (capture),
    .load   (branch),
    .hold   (pc_hold),
    .target (branch_target),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ir_out    <= '0;
      pc_out    <= '0;
      out_valid <= 1'b0;
`ifdef IF_HALT_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
        end

        RUN, HOLD: begin
          if (branch) begin
            // Drop the in-flight word; the target is fetched next cycle.
            out_valid <= 1'b0;
            state     <= RUN;
          end else if (capture) begin
            ir_out    <= mem_instr;
            pc_out    <= pc;
            out_valid <= 1'b1;
`ifdef IF_HALT_EN
            if (halt_hit) begin
              halted_q <= 1'b1;
              state    <= HALT;
            end else begin
              state    <= RUN;
            end
`else
            state     <= RUN;
`endif
          end else begin
            state <= HOLD;
          end
        end

`ifdef IF_HALT_EN
        HALT: begin
          // Offer the halt word once, then go quiet until reset.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
